// File: rtl/prefix_add_pipe.sv
// prefix_add_pipe
// ---------------------------------------------------------------------------
// Pipelined Kogge-Stone parallel-prefix adder with a valid/ready stream
// interface and two's-complement overflow reporting.
//
//   {cOut, s} = x + y' + cIn, with y' = y (or ~y when sub=1 and the optional
//   subtract port is built in).
//
// Parameters
//   WIDTH  operand/sum width, 2..128
//   LPS    Kogge-Stone prefix levels per pipeline stage, 1..clog2(WIDTH)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   x, y       operands (WIDTH bits)
//   cIn        carry-in
//   inValid    x/y/cIn (and sub) are valid this cycle
//   inReady    block accepts a transfer this cycle
//   s          sum (registered)
//   cOut       carry-out of bit WIDTH-1 (registered)
//   ovf        two's-complement overflow of s (registered)
//   outValid   s/cOut/ovf valid
//   outReady   downstream accepts the result
//   sub        subtract select, only when PREFIX_ADD_SUB_EN is defined
//
// Configuration macro
//   PREFIX_ADD_SUB_EN  adds the sub port; y' = sub ? ~y : y.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// pipeline stalls as a whole while outValid && !outReady (bubbles included),
// so inReady = !(outValid && !outReady) is the only combinational
// input-to-output path.
//
// Pipeline: stage 0 registers per-bit g/p (cIn folded into bit 0), stages
// 1..P each apply up to LPS prefix levels, and a final register stage forms
// s/cOut/ovf. Latency is P+1 cycles, P = ceil(clog2(WIDTH)/LPS).
// ---------------------------------------------------------------------------
module prefix_add_pipe #(
  parameter int WIDTH = 32,
  parameter int LPS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] s,
  output logic             cOut,
  output logic             ovf,
  output logic             outValid,
  input  logic             outReady
`ifdef PREFIX_ADD_SUB_EN
  ,
  input  logic             sub
`endif
);

  localparam int N = $clog2(WIDTH);
  localparam int P = (N + LPS - 1) / LPS;

  // Per-stage state. Index 0 is the g/p stage, P is the last prefix stage.
  logic [WIDTH-1:0] r_g    [0:P];
  logic [WIDTH-1:0] r_p    [0:P];
  logic [WIDTH-1:0] r_praw [0:P];
  logic             r_cin  [0:P];
  logic             r_xm   [0:P];
  logic             r_ym   [0:P];
  logic             r_v    [0:P];

  logic [WIDTH-1:0] w_yp;
  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g    [1:P];
  logic [WIDTH-1:0] w_p    [1:P];
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_stall;

  // Applies Kogge-Stone levels lo..hi-1 (span 2^k at level k) to (g, p).
  function automatic logic [2*WIDTH-1:0] ks_levels(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int               lo,
    input int               hi
  );
    logic [WIDTH-1:0] g, p, g_n, p_n;
    g = g_in;
    p = p_in;
    for (int k = 0; k < N; k++) begin
      g_n = g;
      p_n = p;
      if (k >= lo && k < hi) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i >= (1 << k)) begin
            g_n[i] = g[i] | (p[i] & g[i - (1 << k)]);
            p_n[i] = p[i] & p[i - (1 << k)];
          end
        end
      end
      g = g_n;
      p = p_n;
    end
    return {g, p};
  endfunction

  // Whole-pipeline stall: only a held result blocks anything.
  assign w_stall = outValid & ~outReady;
  assign inReady = ~w_stall;

`ifdef PREFIX_ADD_SUB_EN
  assign w_yp = sub ? ~y : y;
`else
  assign w_yp = y;
`endif

  always_comb begin
    w_p0    = x ^ w_yp;
    w_g0    = x & w_yp;
    // Folding cIn into bit 0 makes G[i] the carry into bit i+1 directly.
    w_g0[0] = (x[0] & w_yp[0]) | (w_p0[0] & cIn);
  end

  always_comb begin
    w_g = '{default: '0};
    w_p = '{default: '0};
    for (int st = 1; st <= P; st++) begin
      {w_g[st], w_p[st]} = ks_levels(r_g[st-1], r_p[st-1], (st - 1) * LPS,
                                     (st * LPS > N) ? N : st * LPS);
    end
  end

  // After the last stage r_g[P][i] is the carry out of bit i.
  assign w_sum = r_praw[P] ^ {r_g[P][WIDTH-2:0], r_cin[P]};
  assign w_ovf = (r_xm[P] == r_ym[P]) && (w_sum[WIDTH-1] != r_xm[P]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int st = 0; st <= P; st++) begin
        r_g[st]    <= '0;
        r_p[st]    <= '0;
        r_praw[st] <= '0;
        r_cin[st]  <= 1'b0;
        r_xm[st]   <= 1'b0;
        r_ym[st]   <= 1'b0;
        r_v[st]    <= 1'b0;
      end
      s        <= '0;
      cOut     <= 1'b0;
      ovf      <= 1'b0;
      outValid <= 1'b0;
    end else if (!w_stall) begin
      // Valid bits always shift; data only loads behind a valid bit.
      r_v[0] <= inValid;
      if (inValid) begin
        r_g[0]    <= w_g0;
        r_p[0]    <= w_p0;
        r_praw[0] <= w_p0;
        r_cin[0]  <= cIn;
        r_xm[0]   <= x[WIDTH-1];
        r_ym[0]   <= w_yp[WIDTH-1];
      end
      for (int st = 1; st <= P; st++) begin
        r_v[st] <= r_v[st-1];
        if (r_v[st-1]) begin
          r_g[st]    <= w_g[st];
          r_p[st]    <= w_p[st];
          r_praw[st] <= r_praw[st-1];
          r_cin[st]  <= r_cin[st-1];
          r_xm[st]   <= r_xm[st-1];
          r_ym[st]   <= r_ym[st-1];
        end
      end
      outValid <= r_v[P];
      if (r_v[P]) begin
        s    <= w_sum;
        cOut <= r_g[P][WIDTH-1];
        ovf  <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_prefix_add_pipe.sv
// tb_prefix_add_pipe
// ---------------------------------------------------------------------------
// Scoreboard bench for prefix_add_pipe. A main 32-bit/LPS=1 instance runs
// directed vectors, a back-pressured stream and a mid-flight reset; a set of
// further instances sweeps WIDTH/LPS with random traffic. Each instance has a
// driver that pushes expected {s, cOut, ovf} plus the accept edge into
// queues, and a separate monitor that pops and compares on every consumed
// output. The reference model works on plain wide integer arithmetic.
// ---------------------------------------------------------------------------
module tb_prefix_add_pipe;

  // ---------------- clock / shared counters ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: true (W+1)-bit unsigned sum and signed range check.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sb);
    logic [31:0] bp;
    logic [32:0] full;
    logic [33:0] sg;
    bp   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {32'd0, ci};
    sg   = {{2{a[31]}}, a} + {{2{bp[31]}}, bp} + {33'd0, ci};
    return {full[31:0], full[32], sg[32] != sg[31]};
  endfunction

  // ---------------- main instance: WIDTH=32, LPS=1 ----------------
  localparam int LAT_M = 6;
  logic        reset;
  logic [31:0] x_m, y_m, s_m;
  logic        cin_m, inv_m, rdy_m, c_m, o_m, ov_m, ordy_m, sub_m;
  logic [33:0] exp_m[$];
  int          acc_m[$];
  int          cyc_m = 0;
  bit          lat_chk_m;

  prefix_add_pipe #(.WIDTH(32), .LPS(1)) u_dut (
    .clk(clk), .reset(reset), .x(x_m), .y(y_m), .cIn(cin_m),
    .inValid(inv_m), .inReady(rdy_m), .s(s_m), .cOut(c_m), .ovf(o_m),
    .outValid(ov_m), .outReady(ordy_m)
`ifdef PREFIX_ADD_SUB_EN
    , .sub(sub_m)
`endif
  );

  always @(posedge clk) cyc_m <= cyc_m + 1;

  // Drive one vector; hold it until accepted; record the expectation.
  task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb, input logic [33:0] e);
    int t;
    t = 0;
    @(negedge clk);
    x_m = a; y_m = b; cin_m = ci; sub_m = sb; inv_m = 1'b1;
    #1;
    while (!rdy_m && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (!rdy_m) begin
      errors++;
      $display("FAIL send_timeout actual=inReady0 required=inReady1");
    end else begin
      exp_m.push_back(e);
      acc_m.push_back(cyc_m + 1);
    end
  endtask

  task automatic idle_m(input int n);
    repeat (n) begin
      @(negedge clk);
      inv_m = 1'b0;
    end
  endtask

  task automatic drain_m();
    int t;
    t = 0;
    while (exp_m.size() != 0 && t < 200) begin
      @(negedge clk);
      inv_m = 1'b0;
      t++;
    end
    chk("main_drain_left", exp_m.size(), 0);
  endtask

  // Monitor for the main instance.
  initial begin : mon_m
    logic        prev_stall;
    logic [33:0] prev;
    logic [33:0] e;
    int          a;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_stall = 1'b0;
        continue;
      end
      chk("main_inready", rdy_m, !(ov_m && !ordy_m));
      if (prev_stall) begin
        chk("main_hold_valid", ov_m, 1'b1);
        chk("main_hold_data", {s_m, c_m, o_m}, prev);
      end
      if (ov_m && ordy_m) begin
        checks++;
        if (exp_m.size() == 0) begin
          errors++;
          $display("FAIL main_spurious actual=s%0h required=no_output", s_m);
        end else begin
          e = exp_m.pop_front();
          a = acc_m.pop_front();
          if ({s_m, c_m, o_m} !== e) begin
            errors++;
            $display("FAIL main_result actual=s%0h c%0b o%0b required=s%0h c%0b o%0b",
                     s_m, c_m, o_m, e[33:2], e[1], e[0]);
          end
          if (lat_chk_m) chk("main_latency", cyc_m - a, LAT_M);
        end
      end
      prev_stall = ov_m && !ordy_m;
      prev = {s_m, c_m, o_m};
    end
  end

  // ---------------- sweep instances ----------------
  localparam int NCFG = 8;
  localparam int CFG_W [NCFG] = '{2, 8, 8, 13, 13, 64, 64, 32};
  localparam int CFG_L [NCFG] = '{1, 1, 3, 1, 4, 1, 6, 5};

  for (genvar c = 0; c < NCFG; c++) begin : g_sw
    localparam int W  = CFG_W[c];
    localparam int LP = CFG_L[c];
    localparam int PP = ($clog2(W) + LP - 1) / LP;

    logic [W-1:0] sx, sy, ss;
    logic         srst, sci, sv, srdy, sc, so, sov, sordy, ssb;
    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           cyc = 0;
    bit           lat_chk;

    prefix_add_pipe #(.WIDTH(W), .LPS(LP)) u_dut (
      .clk(clk), .reset(srst), .x(sx), .y(sy), .cIn(sci),
      .inValid(sv), .inReady(srdy), .s(ss), .cOut(sc), .ovf(so),
      .outValid(sov), .outReady(sordy)
`ifdef PREFIX_ADD_SUB_EN
      , .sub(ssb)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
      logic [W-1:0] bp;
      logic [W:0]   full;
      logic [W+1:0] sg;
      bp   = sb ? ~b : b;
      full = {1'b0, a} + {1'b0, bp} + (W+1)'(ci);
      sg   = {{2{a[W-1]}}, a} + {{2{bp[W-1]}}, bp} + (W+2)'(ci);
      return {full[W-1:0], full[W], sg[W] != sg[W-1]};
    endfunction

    function automatic logic [W-1:0] rnd_op();
      logic [63:0] r;
      int k;
      r = {$urandom, $urandom};
      k = $urandom_range(0, 7);
      if (k == 0) return '1;
      if (k == 1) return '0;
      return r[W-1:0];
    endfunction

    // Random traffic: phase 0 with outReady held 1 (latency checked),
    // phase 1 with random back-pressure.
    initial begin : drv
      int  n, t, cnt;
      bit  acc;
      srst = 1'b1; sv = 1'b0; sx = '0; sy = '0; sci = 1'b0; ssb = 1'b0; sordy = 1'b1;
      repeat (3) @(negedge clk);
      srst = 1'b0;
      for (int ph = 0; ph < 2; ph++) begin
        lat_chk = (ph == 0);
        cnt = (ph == 0) ? 300 : 700;
        n = 0; t = 0; acc = 1'b0;
        while (n < cnt && t < 5000) begin
          @(negedge clk);
          if (acc) begin
            sv = 1'b0;
            acc = 1'b0;
          end
          sordy = (ph == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
          if (!sv && $urandom_range(0, 9) < 7) begin
            sx = rnd_op(); sy = rnd_op(); sci = 1'($urandom_range(0, 1));
`ifdef PREFIX_ADD_SUB_EN
            ssb = 1'($urandom_range(0, 1));
`endif
            sv = 1'b1;
          end
          #1;
          if (sv && srdy) begin
            exp_q.push_back(model(sx, sy, sci, ssb));
            acc_q.push_back(cyc + 1);
            acc = 1'b1;
            n++;
          end
          t++;
        end
        chk($sformatf("sw%0d_sent", c), n, cnt);
        @(negedge clk);
        sv = 1'b0;
        sordy = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
          @(negedge clk);
          t++;
        end
        chk($sformatf("sw%0d_drain_left", c), exp_q.size(), 0);
      end
      done_cnt++;
    end

    initial begin : mon
      logic         prev_stall;
      logic [W+1:0] prev;
      logic [W+1:0] e;
      int           a;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
        @(negedge clk);
        #2;
        if (srst) begin
          prev_stall = 1'b0;
          continue;
        end
        chk($sformatf("sw%0d_inready", c), srdy, !(sov && !sordy));
        if (prev_stall) chk($sformatf("sw%0d_hold", c), {sov, ss, sc, so}, {1'b1, prev});
        if (sov && sordy) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sw%0d_spurious actual=s%0h required=no_output", c, ss);
          end else begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            if ({ss, sc, so} !== e) begin
              errors++;
              $display("FAIL sw%0d_result W=%0d LPS=%0d actual=%0h required=%0h",
                       c, W, LP, {ss, sc, so}, e);
            end
            if (lat_chk) chk($sformatf("sw%0d_latency", c), cyc - a, PP + 1);
          end
        end
        prev_stall = sov && !sordy;
        prev = {ss, sc, so};
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    logic [31:0] va [10];
    logic [31:0] vb [10];
    logic        vc [10];
    int          idx, t;

    reset = 1'b1; x_m = '0; y_m = '0; cin_m = 1'b0; inv_m = 1'b0;
    ordy_m = 1'b1; sub_m = 1'b0; lat_chk_m = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outvalid", ov_m, 1'b0);
    chk("rst_sum", {s_m, c_m, o_m}, 34'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_inready", rdy_m, 1'b1);

    // Directed: simple add, wrap with carry, signed overflow.
    send_m(32'h2, 32'h2, 1'b0, 1'b0, {32'h4, 1'b0, 1'b0});
    idle_m(10);
    chk("main_one_shot_drained", exp_m.size(), 0);
    send_m(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {32'h0, 1'b1, 1'b0});
    send_m(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1});
    send_m(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, {32'h0, 1'b1, 1'b1});
    idle_m(1);
    drain_m();

`ifdef PREFIX_ADD_SUB_EN
    send_m(32'd5, 32'd7, 1'b1, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0});
    send_m(32'h8000_0000, 32'h1, 1'b1, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1});
    idle_m(1);
    drain_m();
`endif

    // Streaming: 10 back-to-back vectors, outReady dropped for 3 cycles
    // while results are flowing.
    lat_chk_m = 1'b0;
    for (int i = 0; i < 10; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vc[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; t = 0;
    while (idx < 10 && t < 100) begin
      @(negedge clk);
      ordy_m = !(t >= 7 && t <= 9);
      x_m = va[idx]; y_m = vb[idx]; cin_m = vc[idx]; sub_m = 1'b0; inv_m = 1'b1;
      #1;
      if (rdy_m) begin
        exp_m.push_back(model32(va[idx], vb[idx], vc[idx], 1'b0));
        acc_m.push_back(cyc_m + 1);
        idx++;
      end
      t++;
    end
    chk("stream_sent", idx, 10);
    @(negedge clk);
    inv_m = 1'b0;
    ordy_m = 1'b1;
    drain_m();
    lat_chk_m = 1'b1;

    // Reset with four operations in flight.
    for (int i = 0; i < 4; i++) send_m($urandom, $urandom, 1'b0, 1'b0, 34'd0);
    @(negedge clk);
    inv_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_outvalid", ov_m, 1'b0);
    chk("midrst_sum", s_m, 32'd0);
    exp_m.delete();
    acc_m.delete();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_inready", rdy_m, 1'b1);
    idle_m(12);
    send_m(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {32'h2345_678A, 1'b0, 1'b0});
    idle_m(1);
    drain_m();

    // Wait for the sweep instances.
    t = 0;
    while (done_cnt < NCFG && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_done", done_cnt, NCFG);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_add_pipe.md
# prefix_add_pipe

Parametrised, pipelined Kogge-Stone parallel-prefix adder with a valid/ready stream interface. It is the next-generation adder used wherever multi-cycle datapaths need a wide add at full clock rate. It extends the fixed 32-bit combinational prefix adder in four ways:
- generic operand width;
- configurable pipeline depth;
- back-pressure;
- signed-overflow reporting.

## Interface
Parameters:
- WIDTH, 32, operand/sum width in bits; legal range 2..128.
- LPS, 1, prefix levels per pipeline stage; legal range 1..clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- cIn  input  1  carry-in.
- inValid  input  1  x/y/cIn valid this cycle.
- inReady  output  1  block accepts a transfer this cycle.
- s  output  WIDTH  sum.
- cOut  output  1  carry-out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow of s.
- outValid  output  1  s/cOut/ovf valid.
- outReady  input  1  downstream accepts the result.
- sub  input  1  only present when PREFIX_ADD_SUB_EN is defined; see Configuration.

## Operation
- Computes {cOut, s} = x + y' + cIn, where y' is y (or ~y in subtract mode).
  - ovf = (x[W-1] == y'[W-1]) && (s[W-1] != x[W-1]).
- Number of prefix levels: N = clog2(WIDTH).
- Number of prefix stages: P = ceil(N/LPS).
- Stage 0 registers per-bit g/p:
  - g[i] = x[i]&y'[i], p[i] = x[i]^y'[i].
  - cIn is folded into bit 0: g[0] = x0&y'0 | p0&cIn.
  - Raw p and x[W-1]/y'[W-1] are carried alongside for the sum and overflow.
- Stages 1..P each perform LPS Kogge-Stone levels (fewer in the last stage if N is not a multiple of LPS), using the operator (G,P)∘(G',P') = (G | P&G', P&P'), with span 2^k at level k.
- Final stage result:
  - s[0] = p[0]^cIn;
  - s[i] = p[i]^G[i-1:0];
  - cOut = G[W-1:0].
  - All three outputs are registered.
- Every stage holds a valid bit. Data registers load only when their stage advances; valid bits propagate with the data.
- Stall: stall = outValid && !outReady. While stalled, every stage holds, including bubble stages (bubbles are not collapsed).
- inReady = !stall. A transfer occurs when inValid && inReady.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Latency L = P + 1 cycles: an input accepted at edge k gives outValid=1 with its result after edge k+L.
  - WIDTH=32, LPS=1: L = 6.
  - WIDTH=32, LPS=5: L = 2.
- Throughput is one result per cycle while outReady=1.
- outValid, s, cOut and ovf are stable while outValid && !outReady.
- A result is consumed at the edge where outValid && outReady. A new input accepted on the same edge is not blocked.
- Reset (asynchronous assert, any cycle):
  - all valid bits go to 0;
  - s=0, cOut=0, ovf=0;
  - in-flight operations are discarded;
  - inReady is 1 in the first cycle after reset deasserts.
- inReady depends combinationally on outReady. There is no other combinational input-to-output path.

## Configuration
- PREFIX_ADD_SUB_EN defined:
  - adds the port sub, sampled with x/y/cIn;
  - y' = sub ? ~y : y, so x − y requires sub=1 and cIn=1;
  - cOut=1 means no borrow;
  - sub travels with its operands through stage 0 only.
- Not defined:
  - no sub port;
  - y' = y;
  - logic is identical otherwise.

## Test plan
- WIDTH=32, LPS=1, outReady=1: x=0x00000002, y=0x00000002, cIn=0 → after 6 cycles s=0x00000004, cOut=0, ovf=0, outValid=1 for one cycle.
- Wrap and carry: x=0xFFFFFFFF, y=0x00000000, cIn=1 → s=0x00000000, cOut=1, ovf=0. Then x=0x7FFFFFFF, y=0x00000001, cIn=0 → s=0x80000000, cOut=0, ovf=1.
- Streaming plus back-pressure:
  - Drive 10 back-to-back random vectors and drop outReady for 3 cycles mid-stream.
  - Expected: inReady low exactly while outValid && !outReady, all 10 results match the reference model in order, and none are lost or duplicated.
- Reset mid-operation: assert reset with 4 operations in flight → outValid=0 and s=0 immediately. Nothing emerges after release until a new input is accepted.
- Parameter sweep over WIDTH ∈ {2,8,13,64} and LPS ∈ {1, clog2(WIDTH)}, using 1000 random vectors → exact match on s/cOut/ovf, with latency equal to P+1.
- With PREFIX_ADD_SUB_EN: x=5, y=7, sub=1, cIn=1 (WIDTH=8) → s=0xFE, cOut=0, ovf=0. Then x=0x80, y=0x01, sub=1, cIn=1 → s=0x7F, ovf=1.
